// File: rtl/dct_coeff_serializer.sv
// dct_coeff_serializer
//
// Sits on the output side of the 8x8 DCT. On a coeff_load strobe it captures all
// 64 parallel 32-bit coefficients into a shadow array. It then streams them out one
// per accepted valid/ready handshake, in JPEG zigzag order. Each sample is
// sign-extended, rounded half-up, arithmetically shifted right by SHIFT, and
// saturated to a signed OUT_W-bit value.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   coeff_in    64 x 32-bit signed coefficients, row-major (Drc at word (r-1)*8+(c-1))
//   coeff_load  1-cycle strobe: capture coeff_in and start a block (when idle or on final accept)
//   out_data    scaled, saturated coefficient (signed OUT_W)
//   out_index   raster index of out_data
//   out_valid   out_data/out_index/out_last are valid
//   out_ready   downstream accept (handshake when out_valid && out_ready)
//   out_last    marks zigzag position 63 (D88)
//   busy        block captured and not yet fully accepted
//   overrun     1-cycle pulse: coeff_load ignored because a block was in flight
module dct_coeff_serializer #(
    parameter int SHIFT = 8,
    parameter int OUT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2047:0]           coeff_in,
    input  logic                    coeff_load,
    output logic signed [OUT_W-1:0] out_data,
    output logic [5:0]              out_index,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    busy,
    output logic                    overrun
);

    // Zigzag scan position -> raster index.
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    // Half-LSB rounding term; (1<<SHIFT)>>1 yields 0 for SHIFT=0 without a negative shift.
    localparam logic signed [32:0] RND     = (33'sd1 <<< SHIFT) >>> 1;
    localparam logic signed [32:0] SAT_MAX = (33'sd1 <<< (OUT_W - 1)) - 33'sd1;
    localparam logic signed [32:0] SAT_MIN = -(33'sd1 <<< (OUT_W - 1));

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t             state;
    logic [5:0]         cnt;
    logic signed [31:0] shadow [64];

    logic       accept;
    logic       final_accept;
    logic       load_ok;
    logic [5:0] cnt_nxt;
    logic [5:0] raster_nxt;

    // Sign-extend to 33 bits so the rounding add of a max positive word cannot wrap.
    function automatic logic signed [32:0] round_shift(input logic signed [31:0] w);
        logic signed [32:0] ext;
        ext = {w[31], w};
        return (ext + RND) >>> SHIFT;
    endfunction

    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [32:0] v);
        logic signed [32:0] clip;
        if (v > SAT_MAX)
            clip = SAT_MAX;
        else if (v < SAT_MIN)
            clip = SAT_MIN;
        else
            clip = v;
        return clip[OUT_W-1:0];
    endfunction

    assign accept       = out_valid && out_ready;
    assign final_accept = accept && (cnt == 6'd63);
    // A new block is taken when idle, or back-to-back on the accept of the last sample.
    assign load_ok      = coeff_load && ((state == IDLE) || final_accept);
    assign cnt_nxt      = cnt + 6'd1;
    assign raster_nxt   = ZZ[cnt_nxt];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 6'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            out_data  <= '0;
            out_index <= 6'd0;
            for (int i = 0; i < 64; i++)
                shadow[i] <= 32'sd0;
        end else begin
            overrun <= coeff_load && (state == SEND) && !final_accept;

            if (load_ok) begin
                for (int i = 0; i < 64; i++)
                    shadow[i] <= coeff_in[32*i +: 32];
                state     <= SEND;
                cnt       <= 6'd0;
                busy      <= 1'b1;
                out_valid <= 1'b1;
                out_last  <= 1'b0;
                // Zigzag position 0 is raster 0; take it straight from the input
                // because the shadow array is only being written on this edge.
                out_data  <= saturate(round_shift(coeff_in[31:0]));
                out_index <= 6'd0;
            end else if (accept) begin
                if (cnt == 6'd63) begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end else begin
                    cnt       <= cnt_nxt;
                    out_data  <= saturate(round_shift(shadow[raster_nxt]));
                    out_index <= raster_nxt;
                    out_last  <= (cnt_nxt == 6'd63);
                end
            end
        end
    end

endmodule
